// File: rtl/stereo_decimator_if.sv
// Pixel-in / decimated-pixel-out bundle for stereo_decimator.
// master drives the camera side and the consumer ready; slave is the decimator.
interface stereo_decimator_if;
  logic       frame_start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_row_end;
  logic       out_frame_end;
  logic       overrun;
  logic       busy;

  modport master (
    output frame_start, pix_valid, pix_data, out_ready,
    input  out_data, out_valid, out_row_end, out_frame_end, overrun, busy
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, out_ready,
    output out_data, out_valid, out_row_end, out_frame_end, overrun, busy
  );
endinterface

// File: rtl/stereo_decimator.sv
// Box-average decimator: each 2^S x 2^S tile of an 8-bit raster becomes one pixel,
// emitted a row at a time over a valid/ready stream.
module stereo_decimator #(
  parameter int WIDTH      = 46,
  parameter int HEIGHT     = 30,
  parameter int SCALE_LOG2 = 4
) (
  input logic               clk,
  input logic               reset,
  stereo_decimator_if.slave bus
);
  localparam int S    = SCALE_LOG2;
  localparam int IN_W = WIDTH << S;
  localparam int IN_H = HEIGHT << S;
  localparam int XW   = $clog2(IN_W);
  localparam int YW   = $clog2(IN_H);
  localparam int CW   = XW - S;
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW   = 8 + 2 * S;
  localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_H - 1);
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FULL} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   acc_q      [WIDTH];
  logic [AW-1:0]   acc_d      [WIDTH];
  logic [7:0]      row_buf_q  [WIDTH];
  logic [7:0]      row_buf_d  [WIDTH];
  logic [7:0]      emit_buf_q [WIDTH];
  logic [7:0]      emit_buf_d [WIDTH];
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            overrun_q, overrun_d;

  logic [CW-1:0]   col_idx;
  logic            accept;
  logic            tile_end;
  logic            row_close;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    row_buf_d  = row_buf_q;
    emit_buf_d = emit_buf_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    last_d     = last_q;
    overrun_d  = overrun_q;
    col_idx    = '0;
    accept     = 1'b0;
    tile_end   = 1'b0;
    row_close  = 1'b0;

    if (valid_q && bus.out_ready) begin
      if (idx_q == I_LAST) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (state_q == FULL && !valid_d) state_d = IDLE;

    // frame_start wipes everything first so a same-cycle pixel lands as (0,0)
    if (bus.frame_start) begin
      state_d    = ACCUM;
      x_d        = '0;
      y_d        = '0;
      acc_d      = '{default: '0};
      row_buf_d  = '{default: '0};
      emit_buf_d = '{default: '0};
      idx_d      = '0;
      valid_d    = 1'b0;
      last_d     = 1'b0;
      overrun_d  = 1'b0;
    end

    accept = bus.pix_valid && (bus.frame_start || state_q == ACCUM);

    if (accept) begin
      col_idx   = x_d[XW-1:S];
      tile_end  = (&x_d[S-1:0]) && (&y_d[S-1:0]);
      row_close = tile_end && (x_d == X_LAST);

      if (tile_end) begin
        row_buf_d[col_idx] = 8'((acc_d[col_idx] + AW'(bus.pix_data)) >> (2 * S));
        acc_d[col_idx]     = '0;
      end else begin
        acc_d[col_idx] = acc_d[col_idx] + AW'(bus.pix_data);
      end

      // an emitter finishing its last beat this cycle counts as idle
      if (row_close) begin
        if (!valid_d) begin
          emit_buf_d = row_buf_d;
          idx_d      = '0;
          valid_d    = 1'b1;
          last_d     = (y_d == Y_LAST);
        end else begin
          overrun_d = 1'b1;
        end
      end

      if (x_d == X_LAST) begin
        x_d = '0;
        if (y_d == Y_LAST) begin
          y_d     = '0;
          state_d = FULL;
        end else begin
          y_d = y_d + 1'b1;
        end
      end else begin
        x_d = x_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '{default: '0};
      row_buf_q  <= '{default: '0};
      emit_buf_q <= '{default: '0};
      idx_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      row_buf_q  <= row_buf_d;
      emit_buf_q <= emit_buf_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.out_data      = emit_buf_q[idx_q];
  assign bus.out_valid     = valid_q;
  assign bus.out_row_end   = valid_q && (idx_q == I_LAST);
  assign bus.out_frame_end = valid_q && (idx_q == I_LAST) && last_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_stereo_decimator.sv
// Scoreboard bench for stereo_decimator on a reduced 3x2 output frame with 16x16 tiles.
module tb_stereo_decimator;
  localparam int W    = 3;
  localparam int H    = 2;
  localparam int S    = 4;
  localparam int IN_W = W << S;
  localparam int IN_H = H << S;

  typedef struct packed {
    logic [7:0] d;
    logic       re;
    logic       fe;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset;
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  stereo_decimator_if bus ();

  stereo_decimator #(.WIDTH(W), .HEIGHT(H), .SCALE_LOG2(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int a, input int b, input int c, input bit last_row);
    exp_q.push_back({8'(a), 1'b0, 1'b0});
    exp_q.push_back({8'(b), 1'b0, 1'b0});
    exp_q.push_back({8'(c), 1'b1, last_row});
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int x, input int y);
    case (mode)
      0:       return 8'd100;
      1:       return 8'((x >> 4) * 4);
      2: begin
        if (y < 16 && x < 16)      return 8'd255;
        else if (y < 16 && x < 32) return (x == 20 && y == 5) ? 8'd0 : 8'd255;
        else                       return 8'd0;
      end
      default: return 8'((x >> 4) * 10 + (y >> 4) * 50 + 7);
    endcase
  endfunction

  // fs: 0 = separate frame_start pulse, 1 = frame_start with first pixel, 2 = none
  task automatic run_frame(input int mode, input int fs, input int stop);
    int n = 0;
    if (fs == 0) begin
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
    end
    for (int y = 0; y < IN_H; y++) begin
      for (int x = 0; x < IN_W; x++) begin
        if (stop != 0 && n == stop) begin
          bus.pix_valid = 1'b0;
          return;
        end
        bus.frame_start = (fs == 1) && (x == 0) && (y == 0);
        bus.pix_valid   = 1'b1;
        bus.pix_data    = pix_val(mode, x, y);
        tick();
        n++;
      end
    end
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) return;
    end
    check("drain_timeout", 1, 0);
  endtask

  task automatic monitor();
    bit    fe_prev = 1'b0;
    beat_t got;
    beat_t exp;
    forever begin
      @(negedge clk);
      if (fe_prev) check("busy_after_frame_end", int'(bus.busy), 0);
      fe_prev = 1'b0;
      if (!reset && bus.out_valid && bus.out_ready) begin
        got = {bus.out_data, bus.out_row_end, bus.out_frame_end};
        if (exp_q.size() == 0) begin
          check("extra_beat", int'(got), -1);
        end else begin
          exp = exp_q.pop_front();
          check("beat", int'(got), int'(exp));
        end
        fe_prev = bus.out_frame_end;
      end
    end
  endtask

  task automatic stall_mid_row();
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) begin
      check("stall_wait_timeout", 1, 0);
      return;
    end
    tick();
    bus.out_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", int'(bus.out_valid), 1);
      check("stall_data", int'(bus.out_data), 17);
    end
    tick();
    bus.out_ready = 1'b1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 8'd0;
    bus.out_ready   = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_row_end", int'(bus.out_row_end), 0);
    check("rst_frame_end", int'(bus.out_frame_end), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_busy", int'(bus.busy), 0);
    tick();
    reset = 1'b0;
    tick();

    // flat 100 frame
    push_row(100, 100, 100, 1'b0);
    push_row(100, 100, 100, 1'b1);
    run_frame(0, 0, 0);
    wait_idle(200);
    check("flat_overrun", int'(bus.overrun), 0);

    // column ramp, frame_start coincident with first pixel
    push_row(0, 4, 8, 1'b0);
    push_row(0, 4, 8, 1'b1);
    run_frame(1, 1, 0);
    wait_idle(200);

    // saturated tile and a tile with one dark pixel
    push_row(255, 254, 0, 1'b0);
    push_row(0, 0, 0, 1'b1);
    run_frame(2, 0, 0);
    wait_idle(200);

    // 10-cycle stall right after the first beat of row 0
    push_row(7, 17, 27, 1'b0);
    push_row(57, 67, 77, 1'b1);
    fork
      run_frame(3, 0, 0);
      stall_mid_row();
    join
    wait_idle(200);

    // consumer stalled the whole frame: row 1 dropped
    bus.out_ready = 1'b0;
    push_row(7, 17, 27, 1'b0);
    run_frame(3, 0, 0);
    @(negedge clk);
    check("ovr_overrun_set", int'(bus.overrun), 1);
    check("ovr_busy_held", int'(bus.busy), 1);
    tick();
    bus.out_ready = 1'b1;
    wait_idle(200);
    repeat (5) @(negedge clk);
    check("ovr_no_row1", int'(bus.out_valid), 0);
    check("ovr_sticky", int'(bus.overrun), 1);

    // reset mid-frame, then a fresh frame
    push_row(100, 100, 100, 1'b0);
    run_frame(0, 0, 20 * IN_W + 30);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_overrun", int'(bus.overrun), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("midrst_leftover", exp_q.size(), 0);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    @(negedge clk);
    check("newframe_busy", int'(bus.busy), 1);
    check("newframe_overrun", int'(bus.overrun), 0);
    push_row(7, 17, 27, 1'b0);
    push_row(57, 67, 77, 1'b1);
    tick();
    run_frame(3, 2, 0);
    wait_idle(200);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
